// File: rtl/sub_serial4_pkg.sv
// sub_serial4_pkg: shared constants for the nibble-serial subtractor (slice width, FSM encodings).
// Rev 1.0
`default_nettype none

package sub_serial4_pkg;

    localparam int NIB = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sub_serial4_sub4.sv
// sub4: combinational 4-bit subtract-with-borrow slice built from rippled full subtractors.
// Rev 1.0
`default_nettype none

module sub4
    import sub_serial4_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           bin,
    output logic [NIB-1:0] so,
    output logic           bo
);

    logic [NIB:0] bw_chain;

    assign bw_chain[0] = bin;

    for (genvar i = 0; i < NIB; i++) begin : g_bit
        assign so[i]         = a[i] ^ b[i] ^ bw_chain[i];
        assign bw_chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw_chain[i]);
    end

    assign bo = bw_chain[NIB];

endmodule

`default_nettype wire

// File: rtl/sub_serial4.sv
// sub_serial4: N-bit a - b - bin computed one nibble per clock, LSB nibble first.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN. Rev 1.0
`default_nettype none

module sub_serial4
    import sub_serial4_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] so,
    output logic         bo
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NNIB = N / NIB;
    localparam int KW   = $clog2(NNIB) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NNIB - 1);

    logic [1:0]    state_q,  state_d;
    logic [KW-1:0] k_q,      k_d;
    logic [N-1:0]  a_q,      a_d;
    logic [N-1:0]  b_q,      b_d;
    logic          borrow_q, borrow_d;
    logic [N-1:0]  so_q,     so_d;
    logic          bo_q,     bo_d;
    logic          ovf_q,    ovf_d;

    logic [NIB-1:0] a_nib;
    logic [NIB-1:0] b_nib;
    logic [NIB-1:0] so_nib;
    logic           bo_nib;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int j = 0; j < NNIB; j++) begin
            if (k_q == KW'(j)) begin
                a_nib = a_q[j*NIB +: NIB];
                b_nib = b_q[j*NIB +: NIB];
            end
        end
    end

    sub4 u_sub4 (
        .a   (a_nib),
        .b   (b_nib),
        .bin (borrow_q),
        .so  (so_nib),
        .bo  (bo_nib)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        so_d     = so_q;
        bo_d     = bo_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a start exactly like IDLE so back-to-back ops lose no cycle.
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    k_d      = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int j = 0; j < NNIB; j++) begin
                    if (k_q == KW'(j)) begin
                        so_d[j*NIB +: NIB] = so_nib;
                    end
                end
                borrow_d = bo_nib;
                if (k_q == K_LAST) begin
                    bo_d    = bo_nib;
                    // so[N-1] is being written this cycle, so take it from the slice.
                    ovf_d   = (a_q[N-1] != b_q[N-1]) && (so_nib[NIB-1] != a_q[N-1]);
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            so_q     <= '0;
            bo_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            so_q     <= so_d;
            bo_q     <= bo_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign so   = so_q;
    assign bo   = bo_q;

`ifdef SUB_SIGNED_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub_serial4.sv
// tb_sub_serial4: directed, table-driven self-checking bench for sub_serial4 (N=8).
// Rev 1.0
`default_nettype none

module tb_sub_serial4;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] so;
    logic         bo;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    sub_serial4 #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .so    (so),
        .bo    (bo)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] so;
        logic         bo;
        logic         ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        tick();
        start = 1'b0;
        check("busy_c1", 32'(busy), 32'd1);
        check("done_c1", 32'(done), 32'd0);
        tick();
        check("busy_c2", 32'(busy), 32'd1);
        tick();
        check("done_c3", 32'(done), 32'd1);
        check("busy_c3", 32'(busy), 32'd0);
        check("so",      32'(so),   32'(v.so));
        check("bo",      32'(bo),   32'(v.bo));
`ifdef SUB_SIGNED_OVF_EN
        check("ovf",     32'(ovf),  32'(v.ovf));
`endif
        tick();
        check("done_off", 32'(done), 32'd0);
        check("so_hold",  32'(so),   32'(v.so));
        check("bo_hold",  32'(bo),   32'(v.bo));
    endtask

    initial begin
        vecs[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, so: 8'h23, bo: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, so: 8'hFF, bo: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h01, bin: 1'b1, so: 8'hFE, bo: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h10, b: 8'h00, bin: 1'b1, so: 8'h0F, bo: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, bin: 1'b0, so: 8'h00, bo: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, so: 8'h00, bo: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'h80, b: 8'h01, bin: 1'b0, so: 8'h7F, bo: 1'b0, ovf: 1'b1};
        vecs[7] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, so: 8'h80, bo: 1'b1, ovf: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_so",   32'(so),   32'd0);
        check("rst_bo",   32'(bo),   32'd0);
`ifdef SUB_SIGNED_OVF_EN
        check("rst_ovf",  32'(ovf),  32'd0);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Start while busy is ignored.
        start = 1'b1; a = 8'h50; b = 8'h20; bin = 1'b0;
        tick();
        a = 8'hFF; b = 8'hFF;
        tick();
        start = 1'b0;
        tick();
        check("busy_ign_done", 32'(done), 32'd1);
        check("busy_ign_so",   32'(so),   32'h30);
        check("busy_ign_bo",   32'(bo),   32'd0);
        tick();
        check("busy_ign_idle", 32'(busy), 32'd0);
        check("busy_ign_nodn", 32'(done), 32'd0);

        // Back-to-back start in the DONE cycle.
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_so1",   32'(so),   32'h23);
        start = 1'b1; a = 8'h10; b = 8'h00; bin = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy",  32'(busy), 32'd1);
        check("b2b_nodn",  32'(done), 32'd0);
        tick();
        check("b2b_busy2", 32'(busy), 32'd1);
        tick();
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_so2",   32'(so),   32'h0F);
        check("b2b_bo2",   32'(bo),   32'd0);
        tick();

        // Reset one cycle after start abandons the operation.
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        tick();
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_so",   32'(so),   32'd0);
        check("mid_rst_bo",   32'(bo),   32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst_nodone", 32'(done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
